// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use hazard detection and EX operand forwarding control
// Tracks destination tags through ID/EX, EX/MEM, MEM/WB and derives mux selects and stall/flush controls.
module hazard_forward_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count
);

  logic       ex_valid, ex_regwrite, ex_memread;
  logic [4:0] ex_dest, ex_rs, ex_rt;
  logic       mem_valid, mem_regwrite;
  logic [4:0] mem_dest;
  logic       wb_valid, wb_regwrite;
  logic [4:0] wb_dest;

  logic mem_hit, wb_hit, load_use;

  // A stage can only forward when it really writes a nonzero register.
  assign mem_hit = mem_valid & mem_regwrite & (mem_dest != 5'd0);
  assign wb_hit  = wb_valid  & wb_regwrite  & (wb_dest  != 5'd0);

  assign fwd_a = !ex_valid                      ? 2'b00 :
                 (mem_hit && mem_dest == ex_rs) ? 2'b10 :
                 (wb_hit  && wb_dest  == ex_rs) ? 2'b01 : 2'b00;

  assign fwd_b = !ex_valid                      ? 2'b00 :
                 (mem_hit && mem_dest == ex_rt) ? 2'b10 :
                 (wb_hit  && wb_dest  == ex_rt) ? 2'b01 : 2'b00;

  assign load_use = id_valid & ex_valid & ex_memread & (ex_dest != 5'd0) &
                    ((ex_dest == id_rs) | (ex_dest == id_rt));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (ex_branch_taken) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_dest      <= 5'd0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_dest     <= 5'd0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_dest      <= 5'd0;
      stall_count  <= '0;
    end else begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_dest      <= mem_dest;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_dest     <= ex_dest;
      if (idex_bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_dest     <= 5'd0;
        ex_rs       <= 5'd0;
        ex_rt       <= 5'd0;
      end else begin
        ex_valid    <= id_valid;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_dest     <= id_dest;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
      end
      if (load_use && !ex_branch_taken && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - scoreboard bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  logic        clk, rst_n;
  logic        id_valid, id_regwrite, id_memread, ex_branch_taken;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic        pc_write2, ifid_write2, idex_bubble2, ifid_flush2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] PASS  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1111;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] ctl;
    int         sc;
    int         sc2;
  } exp_t;

  exp_t sb[$];

  hazard_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .stall_count(stall_count)
  );

  hazard_forward_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .ex_branch_taken(ex_branch_taken), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .pc_write(pc_write2), .ifid_write(ifid_write2), .idex_bubble(idex_bubble2),
    .ifid_flush(ifid_flush2), .stall_count(stall_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one ID-stage instruction and queue the outputs expected in that cycle.
  task automatic cyc(input string tag, input logic v, input int rs, input int rt,
                     input int dest, input logic rw, input logic mr, input logic br,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] ctl,
                     input int sc, input int sc2);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_dest = 5'(dest);
    id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.sc = sc; e.sc2 = sc2;
    sb.push_back(e);
  endtask

  task automatic nop(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input int sc, input int sc2);
    cyc(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, fa, fb, PASS, sc, sc2);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_val({e.tag, ".fwd_a"}, int'(fwd_a), int'(e.fa));
      check_val({e.tag, ".fwd_b"}, int'(fwd_b), int'(e.fb));
      check_val({e.tag, ".ctl"}, int'({pc_write, ifid_write, idex_bubble, ifid_flush}), int'(e.ctl));
      check_val({e.tag, ".stall_count"}, int'(stall_count), e.sc);
      check_val({e.tag, ".stall_count2"}, int'(stall_count2), e.sc2);
    end
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b1; id_rs = 5'd2; id_rt = 5'd2; id_dest = 5'd2;
    id_regwrite = 1'b1; id_memread = 1'b1; ex_branch_taken = 1'b0;
    #3;
    check_val("rst.fwd_a", int'(fwd_a), 0);
    check_val("rst.fwd_b", int'(fwd_b), 0);
    check_val("rst.ctl", int'({pc_write, ifid_write, idex_bubble, ifid_flush}), int'(PASS));
    check_val("rst.stall_count", int'(stall_count), 0);
    #5;
    id_valid = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0;
    #4;
    rst_n = 1'b1;

    // EX/MEM forward: add $3 ; sub $5,$3,$4
    cyc("exmem.add", 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    cyc("exmem.sub", 1, 3, 4, 5, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    nop("exmem.sub_in_ex", 2'b10, 2'b00, 0, 0);
    nop("exmem.idle", 2'b00, 2'b00, 0, 0);

    // Priority: add $3 ; or $3 ; and $6,$3,$3 ; then xor $8,$6,$3 gets 01 two cycles after and
    cyc("prio.add", 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    cyc("prio.or", 1, 1, 2, 3, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    cyc("prio.and", 1, 3, 3, 6, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    nop("prio.and_in_ex", 2'b10, 2'b10, 0, 0);
    cyc("prio.xor", 1, 6, 3, 8, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    nop("prio.xor_in_ex", 2'b01, 2'b00, 0, 0);

    // $zero is never forwarded
    cyc("zero.add", 1, 1, 2, 0, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    cyc("zero.sub", 1, 0, 0, 5, 1, 0, 0, 2'b00, 2'b00, PASS, 0, 0);
    nop("zero.sub_in_ex", 2'b00, 2'b00, 0, 0);
    nop("zero.idle", 2'b00, 2'b00, 0, 0);

    // Load-use: lw $2 ; add $4,$2,$7 (held one cycle)
    cyc("lu.lw", 1, 9, 2, 2, 1, 1, 0, 2'b00, 2'b00, PASS, 0, 0);
    cyc("lu.stall", 1, 2, 7, 4, 1, 0, 0, 2'b00, 2'b00, STALL, 0, 0);
    cyc("lu.release", 1, 2, 7, 4, 1, 0, 0, 2'b00, 2'b00, PASS, 1, 1);
    nop("lu.add_in_ex", 2'b01, 2'b00, 1, 1);
    nop("lu.idle", 2'b00, 2'b00, 1, 1);

    // Branch flush overrides the load-use stall
    cyc("fl.lw", 1, 9, 2, 2, 1, 1, 0, 2'b00, 2'b00, PASS, 1, 1);
    cyc("fl.flush", 1, 2, 7, 4, 1, 0, 1, 2'b00, 2'b00, FLUSH, 1, 1);
    nop("fl.after", 2'b00, 2'b00, 1, 1);

    // Repeated load-use stalls saturate the 2-bit counter
    for (int r = 0; r < 5; r++) begin
      cyc($sformatf("sat%0d.lw", r), 1, 9, 2, 2, 1, 1, 0,
          (r == 0) ? 2'b00 : 2'b01, 2'b00, PASS, 1 + r, (1 + r > 3) ? 3 : 1 + r);
      cyc($sformatf("sat%0d.stall", r), 1, 2, 7, 4, 1, 0, 0,
          2'b00, 2'b00, STALL, 1 + r, (1 + r > 3) ? 3 : 1 + r);
      cyc($sformatf("sat%0d.release", r), 1, 2, 7, 4, 1, 0, 0,
          2'b00, 2'b00, PASS, 2 + r, (2 + r > 3) ? 3 : 2 + r);
    end

    // Reset asserted in the middle of a stall releases it immediately
    cyc("rs.lw", 1, 9, 2, 2, 1, 1, 0, 2'b01, 2'b00, PASS, 6, 3);
    cyc("rs.stall", 1, 2, 7, 4, 1, 0, 0, 2'b00, 2'b00, STALL, 6, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rs.ctl", int'({pc_write, ifid_write, idex_bubble, ifid_flush}), int'(PASS));
    check_val("rs.stall_count", int'(stall_count), 0);
    check_val("rs.stall_count2", int'(stall_count2), 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) check_val("drain.pending", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
